// File: rtl/fp_pkg.sv
// Shared floating-point library definitions: min/max mode encoding,
// canonical quiet-NaN patterns and exponent field widths.
package fp_pkg;

  typedef enum logic {
    FP_MODE_MAX = 1'b0,
    FP_MODE_MIN = 1'b1
  } fp_mode_e;

  localparam logic [31:0] FP_QNAN_32 = 32'h7FC0_0000;
  localparam logic [63:0] FP_QNAN_64 = 64'h7FF8_0000_0000_0000;

  localparam int unsigned FP_EXP_W_32 = 8;
  localparam int unsigned FP_EXP_W_64 = 11;

endpackage

// File: rtl/fcmp_total.sv
// Combinational IEEE-754 total-order compare: x_gt_y when key(x) > key(y),
// key = ~x for negative values, x with the MSB set otherwise.
module fcmp_total #(
  parameter int DataWidth = 32
) (
  input  logic [DataWidth-1:0] x,
  input  logic [DataWidth-1:0] y,
  output logic                 x_gt_y
);

  logic [DataWidth-1:0] key_x;
  logic [DataWidth-1:0] key_y;

  always_comb begin
    key_x = x[DataWidth-1] ? ~x : {1'b1, x[DataWidth-2:0]};
    key_y = y[DataWidth-1] ? ~y : {1'b1, y[DataWidth-2:0]};
    x_gt_y = key_x > key_y;
  end

endmodule

// File: rtl/fminmax_reduce.sv
// Streaming FP min/max reduction with argmin/argmax index over Length elements.
// Optional NaN propagation is enabled by defining FMINMAX_NAN_PROPAGATE_EN.
module fminmax_reduce
  import fp_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int ExpWidth  = 8,
  parameter int Length    = 8,
  parameter int IdxWidth  = (Length > 1) ? $clog2(Length) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipeEn,
  input  logic                 go,
  input  logic                 mode,
  input  logic [DataWidth-1:0] a,
  output logic [DataWidth-1:0] result,
  output logic [IdxWidth-1:0]  idx,
  output logic                 rdy
);

  localparam logic [IdxWidth-1:0] CNT_LAST = IdxWidth'(Length - 1);

  logic [IdxWidth-1:0]  cnt;

  logic                 s1_vld;
  logic                 s1_first;
  logic                 s1_last;
  logic [IdxWidth-1:0]  s1_idx;
  logic [DataWidth-1:0] s1_val;
  fp_mode_e             s1_mode;

  logic                 s2_last;
  logic [DataWidth-1:0] acc_val;
  logic [IdxWidth-1:0]  acc_idx;
  fp_mode_e             acc_mode;

  logic [DataWidth-1:0] cmp_x;
  logic [DataWidth-1:0] cmp_y;
  logic                 better;

  // S1: input register and element counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      s1_val   <= '0;
      s1_mode  <= FP_MODE_MAX;
    end else if (pipeEn) begin
      s1_vld <= go;
      if (go) begin
        s1_val   <= a;
        s1_mode  <= fp_mode_e'(mode);
        s1_idx   <= cnt;
        s1_first <= (cnt == '0);
        s1_last  <= (cnt == CNT_LAST);
        cnt      <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Min mode reuses the single comparator with swapped operands.
  always_comb begin
    cmp_x = (acc_mode == FP_MODE_MIN) ? acc_val : s1_val;
    cmp_y = (acc_mode == FP_MODE_MIN) ? s1_val  : acc_val;
  end

  fcmp_total #(
    .DataWidth(DataWidth)
  ) u_cmp (
    .x      (cmp_x),
    .y      (cmp_y),
    .x_gt_y (better)
  );

`ifdef FMINMAX_NAN_PROPAGATE_EN
  localparam logic [DataWidth-1:0] QNAN = (DataWidth == 64) ? DataWidth'(FP_QNAN_64)
                                                            : DataWidth'(FP_QNAN_32);
  logic acc_nan;
  logic elem_nan;

  always_comb begin
    elem_nan = (&s1_val[DataWidth-2 -: ExpWidth]) && (|s1_val[DataWidth-ExpWidth-2:0]);
  end
`endif

  // S2: accumulator; strict improvement only, so ties keep the earliest index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_last  <= 1'b0;
      acc_val  <= '0;
      acc_idx  <= '0;
      acc_mode <= FP_MODE_MAX;
`ifdef FMINMAX_NAN_PROPAGATE_EN
      acc_nan  <= 1'b0;
`endif
    end else if (pipeEn) begin
      s2_last <= s1_vld && s1_last;
      if (s1_vld) begin
        if (s1_first) begin
          acc_val  <= s1_val;
          acc_idx  <= '0;
          acc_mode <= s1_mode;
`ifdef FMINMAX_NAN_PROPAGATE_EN
          acc_nan  <= elem_nan;
        end else if (!acc_nan) begin
          if (elem_nan) begin
            acc_nan <= 1'b1;
            acc_idx <= s1_idx;
          end else if (better) begin
            acc_val <= s1_val;
            acc_idx <= s1_idx;
          end
`else
        end else if (better) begin
          acc_val <= s1_val;
          acc_idx <= s1_idx;
`endif
        end
      end
    end
  end

  // Output register: rdy pulses once per vector and stretches across stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      idx    <= '0;
      rdy    <= 1'b0;
    end else if (pipeEn) begin
      rdy <= s2_last;
      if (s2_last) begin
        idx    <= acc_idx;
`ifdef FMINMAX_NAN_PROPAGATE_EN
        result <= acc_nan ? QNAN : acc_val;
`else
        result <= acc_val;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fminmax_reduce.sv
// Directed self-checking bench for fminmax_reduce: single-width Length=4
// instance plus a double-width instance for the NaN case.
module tb_fminmax_reduce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipeEn = 1'b1;
  logic        go = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] a = '0;
  logic [63:0] a64 = '0;

  logic [31:0] result;
  logic [1:0]  idx;
  logic        rdy;
  logic [63:0] result64;
  logic [1:0]  idx64;
  logic        rdy64;

  int n_cmp = 0;
  int n_err = 0;

  int          pulses = 0;
  logic        rdy_q = 1'b0;
  logic [31:0] got_res[$];
  int          got_idx[$];

  always #5 clk = ~clk;

  fminmax_reduce #(
    .DataWidth(32),
    .ExpWidth (8),
    .Length   (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pipeEn (pipeEn),
    .go     (go),
    .mode   (mode),
    .a      (a),
    .result (result),
    .idx    (idx),
    .rdy    (rdy)
  );

  fminmax_reduce #(
    .DataWidth(64),
    .ExpWidth (11),
    .Length   (4)
  ) dut64 (
    .clk    (clk),
    .rst    (rst),
    .pipeEn (pipeEn),
    .go     (go),
    .mode   (mode),
    .a      (a64),
    .result (result64),
    .idx    (idx64),
    .rdy    (rdy64)
  );

  // Records every rising edge of rdy with the value presented
  always @(negedge clk) begin
    if (rdy && !rdy_q) begin
      pulses++;
      got_res.push_back(result);
      got_idx.push_back(int'(idx));
    end
    rdy_q <= rdy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input logic m, input logic [63:0] v64);
    go   = 1'b1;
    a    = v;
    mode = m;
    a64  = v64;
    step();
    go = 1'b0;
  endtask

  task automatic run_vec(input logic [0:3][31:0] v, input logic [0:3] m,
                         input logic [0:3][63:0] v64, input logic [31:0] er,
                         input int ei, input string tag);
    for (int i = 0; i < 4; i++) send(v[i], m[i], v64[i]);
    check({tag, "_rdy_e0"}, 64'(rdy), 64'd0);
    step();
    check({tag, "_rdy_e1"}, 64'(rdy), 64'd0);
    step();
    check({tag, "_rdy_e2"}, 64'(rdy), 64'd1);
    check({tag, "_res"}, 64'(result), 64'(er));
    check({tag, "_idx"}, 64'(idx), 64'(ei));
    step();
    check({tag, "_rdy_e3"}, 64'(rdy), 64'd0);
  endtask

  initial begin
    logic [0:3][63:0] z64;
    logic [31:0] exp_nan32;
    logic [63:0] exp_nan64;
    z64 = '0;

    step();
    step();
    check("reset_res", 64'(result), 64'd0);
    check("reset_idx", 64'(idx), 64'd0);
    check("reset_rdy", 64'(rdy), 64'd0);
    rst = 1'b0;
    step();

    run_vec({32'h3f6d24f7, 32'h3fdbad77, 32'h3f06c8af, 32'h3e9e9b9a}, 4'b0000, z64,
            32'h3fdbad77, 1, "max");
    run_vec({32'h3f6d24f7, 32'h3fdbad77, 32'h3f06c8af, 32'h3e9e9b9a}, 4'b1010, z64,
            32'h3e9e9b9a, 3, "min_toggle");
    run_vec({32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000}, 4'b0000, z64,
            32'h00000000, 1, "zeros_tie");
    run_vec({32'hbf800000, 32'h3f800000, 32'h3f800000, 32'hc0000000}, 4'b1111, z64,
            32'hc0000000, 3, "min_neg");

    // Back-to-back vectors with a 3-cycle stall inside the second
    step();
    pulses = 0;
    got_res.delete();
    got_idx.delete();
    send(32'h3f6d24f7, 1'b0, '0);
    send(32'h3fdbad77, 1'b0, '0);
    send(32'h3f06c8af, 1'b0, '0);
    send(32'h3e9e9b9a, 1'b0, '0);
    send(32'h3f800000, 1'b0, '0);
    send(32'h40000000, 1'b0, '0);
    check("b2b_rdy_before_stall", 64'(rdy), 64'd1);
    pipeEn = 1'b0;
    go     = 1'b1;
    a      = 32'h7f000000;
    repeat (3) step();
    check("b2b_rdy_stretched", 64'(rdy), 64'd1);
    pipeEn = 1'b1;
    send(32'h40400000, 1'b0, '0);
    send(32'h3f000000, 1'b0, '0);
    repeat (4) step();
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_count", 64'(got_res.size()), 64'd2);
    if (got_res.size() == 2) begin
      check("b2b_res0", 64'(got_res[0]), 64'h3fdbad77);
      check("b2b_idx0", 64'(got_idx[0]), 64'd1);
      check("b2b_res1", 64'(got_res[1]), 64'h40400000);
      check("b2b_idx1", 64'(got_idx[1]), 64'd2);
    end

    // Reset after two elements discards the partial vector
    send(32'h7f000000, 1'b0, '0);
    send(32'h7f000000, 1'b0, '0);
    rst = 1'b1;
    step();
    check("rst_mid_res", 64'(result), 64'd0);
    check("rst_mid_rdy", 64'(rdy), 64'd0);
    rst = 1'b0;
    step();
    run_vec({32'h3f800000, 32'h40000000, 32'h40400000, 32'h3f000000}, 4'b0000, z64,
            32'h40400000, 2, "after_rst");

`ifdef FMINMAX_NAN_PROPAGATE_EN
    exp_nan32 = 32'h7fc00000;
    exp_nan64 = 64'h7ff8000000000000;
`else
    exp_nan32 = 32'h7fc00001;
    exp_nan64 = 64'h7ff8000000000001;
`endif
    run_vec({32'hff800000, 32'hff800000, 32'h7fc00001, 32'hff800000}, 4'b0000,
            {64'hfff0000000000000, 64'hfff0000000000000,
             64'h7ff8000000000001, 64'hfff0000000000000},
            exp_nan32, 2, "nan32");
    check("nan64_res", result64, exp_nan64);
    check("nan64_idx", 64'(idx64), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fminmax_reduce.md
# fminmax_reduce

Streaming floating-point min/max reduction unit: consumes one IEEE-754 element per enabled cycle and, after every `Length` elements, emits the extreme value of that vector together with its element index. It generalises the two-input max operator: it adds selectable min or max mode, a parametrised width (single or double), a parametrised vector length, argmax/argmin index output, and an in-house total-order compare in place of the vendor less-than core. It sits in the datapath library alongside the other `pipeEn`-stalled operators and is driven by generated pipeline controllers.

## Interface
Parameters:
- `DataWidth`, 32: element width; 32 = single, 64 = double.
- `ExpWidth`, 8: exponent field width; 8 for single, 11 for double.
- `Length`, 8: elements per vector, ≥ 1.
- `IdxWidth`, `$clog2(Length)` (minimum 1): index width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pipeEn`  in  1  global pipeline enable; low freezes all state.
- `go`  in  1  element valid; an element is accepted when `go && pipeEn`.
- `mode`  in  1  0 = max, 1 = min; sampled on the first element of each vector.
- `a`  in  DataWidth  element value.
- `result`  out  DataWidth  extreme value of the last completed vector.
- `idx`  out  IdxWidth  position (0-based) of `result` within its vector.
- `rdy`  out  1  result valid.

## Operation
- Stage S1 (input register): registers `a`, `mode`, the accept flag, the first flag (count == 0) and the last flag (count == Length-1).
  - The element counter increments on each accept and wraps to 0 after Length-1.
  - With `Length` = 1, every element is both first and last.
- Stage S2 (accumulator): holds `acc_val`, `acc_idx`, `acc_mode`.
  - A first element loads the accumulator unconditionally, with index 0.
  - Any other element replaces the accumulator only if it is strictly better: greater in max mode, less in min mode.
  - Ties keep the earliest index.
- Output: when the S2 element is last, the updated accumulator value/index goes to `result`/`idx` on the next enabled edge and `rdy` = 1. Otherwise, on an enabled edge, `rdy` = 0 and `result`/`idx` hold.
- Compare uses the total-order key:
  - negative: key = ~x;
  - non-negative: key = x with the MSB set;
  - the keys are compared unsigned.
  - Consequences: +0 > −0, −Inf < every finite value, and a denormal compares by magnitude.
- `mode` changes in mid-vector are ignored; `acc_mode` is latched on the first element.
- Back-to-back vectors need no bubble: the first element of vector k+1 may follow the last element of vector k directly.
- Gaps are allowed: `go` low with `pipeEn` high inserts a bubble without affecting the counter or the accumulator.

## Timing
- Latency: `rdy` is high 2 enabled edges after the edge that accepts the last element.
- Throughput: 1 element per cycle, and 1 result per `Length` cycles at full rate.
- `pipeEn` low: S1, S2, the counter and the outputs all hold. `rdy` stays at its value, so a `rdy` pulse is stretched across the stall.
- With `pipeEn` high, `rdy` is a single-cycle pulse per vector.
- Reset values: `result` = 0, `idx` = 0, `rdy` = 0, counter = 0, all S1/S2 valid/flag bits = 0, accumulator = 0.
- Reset asserted mid-vector discards the partial vector; the next accepted element is index 0.
- Only S2 is in the compare path: one key conversion plus a DataWidth-bit unsigned compare per cycle.

## Configuration
- `FMINMAX_NAN_PROPAGATE_EN` defined:
  - NaN detection: exponent all ones and mantissa non-zero.
  - A NaN element sets a sticky per-vector NaN flag, and `idx` freezes at the first NaN's index.
  - `result` is the canonical quiet NaN for the width: 0x7FC00000 for single, 0x7FF8000000000000 for double.
- Undefined: no NaN detection; a NaN is ordered by its raw total-order key. A positive NaN wins in max mode; a negative NaN wins in min mode.

## Structure
- Shared package `fp_pkg`:
  - mode encodings `FP_MODE_MAX` = 0 and `FP_MODE_MIN` = 1;
  - canonical quiet-NaN constants for 32 and 64 bits;
  - exponent widths 8 and 11.
- One combinational sub-module, `fcmp_total` (parameter `DataWidth`):
  - inputs `x`, `y`;
  - output `x_gt_y` by the total-order key.
  - S2 instantiates it once; min mode uses the swapped operands.

## Test plan
1. Max, Length=4, single: elements 0x3f6d24f7, 0x3fdbad77, 0x3f06c8af, 0x3e9e9b9a → `result` = 0x3fdbad77, `idx` = 1, `rdy` high 2 cycles after the 4th accept.
2. Min on the same vector with `mode` = 1 at the first element, toggled mid-vector → `result` = 0x3e9e9b9a, `idx` = 3; the toggle has no effect.
3. Ties and zeros, max: 0x80000000, 0x00000000, 0x00000000, 0x80000000 → `result` = 0x00000000, `idx` = 1.
4. Two back-to-back vectors with `pipeEn` low for 3 cycles in mid-vector 2 → two correct results; `rdy` pulses exactly twice; no element lost or duplicated.
5. Reset after 2 of 4 elements, then 4 new elements 1.0, 2.0, 3.0, 0.5 (0x3f800000, 0x40000000, 0x40400000, 0x3f000000) → `result` = 0x40400000, `idx` = 2.
6. NaN 0x7fc00001 at index 2 of a max vector, double-width build using 0xfff0000000000000 (−Inf) elsewhere:
   - with the macro: `result` = canonical quiet NaN, `idx` = 2;
   - without the macro: the NaN's raw key wins → `result` = the NaN pattern, `idx` = 2.
